// File: rtl/axis_video_frame_chk.sv
// Frame-aligning AXI4-Stream video checker: drops pre-SOF beats, checks line/frame
// geometry against cfg_width_i/cfg_height_i and keeps saturating status counters.
module axis_video_frame_chk #(
    parameter int DW    = 16,
    parameter int CNT_W = 16
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic [DW-1:0]    s_tdata,
    input  logic [DW/8-1:0]  s_tkeep,
    input  logic             s_tuser,
    input  logic             s_tlast,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [DW-1:0]    m_tdata,
    output logic [DW/8-1:0]  m_tkeep,
    output logic             m_tuser,
    output logic             m_tlast,
    output logic             m_tvalid,
    input  logic             m_tready,
    input  logic [11:0]      cfg_width_i,
    input  logic [11:0]      cfg_height_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic [CNT_W-1:0] drop_cnt_o,
    output logic [CNT_W-1:0] err_eol_early_o,
    output logic [CNT_W-1:0] err_eol_late_o,
    output logic [CNT_W-1:0] err_sof_o,
    output logic [11:0]      meas_width_o,
    output logic [11:0]      meas_height_o
);

    typedef enum logic {WAIT_SOF, IN_FRAME} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [11:0]      x, y, w_q, h_q;
    logic             frame_err;

    logic             skid_valid, skid_nxt;
    logic [DW-1:0]    skid_tdata;
    logic [DW/8-1:0]  skid_tkeep;
    logic             skid_tuser, skid_tlast;

    logic             accept, keep, drop, in_frame, chk_en;
    logic             mid_sof, sof_err, early, late, frame_end, frame_ok, err_prior;
    logic [11:0]      eff_w, eff_h, cx, cy;
    logic [12:0]      x1, y1;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic inc);
        return (inc && (c != '1)) ? c + CNT_ONE : c;
    endfunction

    function automatic logic [11:0] sat12(input logic [12:0] v);
        return v[12] ? 12'hFFF : v[11:0];
    endfunction

    // An SOF beat is evaluated against the freshly sampled geometry at position (0,0).
    always_comb begin
        accept    = s_tvalid & s_tready;
        in_frame  = (state == IN_FRAME);
        keep      = accept & (in_frame | s_tuser);
        drop      = accept & ~in_frame & ~s_tuser;
        eff_w     = s_tuser ? cfg_width_i  : w_q;
        eff_h     = s_tuser ? cfg_height_i : h_q;
        cx        = s_tuser ? '0 : x;
        cy        = s_tuser ? '0 : y;
        x1        = {1'b0, cx} + 13'd1;
        y1        = {1'b0, cy} + 13'd1;
        chk_en    = (eff_w != '0) & (eff_h != '0);
        mid_sof   = keep & s_tuser & in_frame & ((x != '0) | (y != '0));
        sof_err   = mid_sof & (w_q != '0) & (h_q != '0);
        early     = keep & chk_en &  s_tlast & (x1 < {1'b0, eff_w});
        late      = keep & chk_en & ~s_tlast & (x1 == {1'b0, eff_w});
        frame_end = keep & chk_en &  s_tlast & (y1 == {1'b0, eff_h});
        err_prior = frame_err & ~s_tuser;
        frame_ok  = frame_end & ~err_prior & ~early;
        skid_nxt  = skid_valid ? (m_tvalid & ~m_tready) : (keep & m_tvalid & ~m_tready);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            s_tready   <= 1'b0;
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
            m_tkeep    <= '0;
            m_tuser    <= 1'b0;
            m_tlast    <= 1'b0;
            skid_valid <= 1'b0;
            skid_tdata <= '0;
            skid_tkeep <= '0;
            skid_tuser <= 1'b0;
            skid_tlast <= 1'b0;
        end else begin
            if (!m_tvalid || m_tready) begin
                if (skid_valid) begin
                    m_tdata  <= skid_tdata;
                    m_tkeep  <= skid_tkeep;
                    m_tuser  <= skid_tuser;
                    m_tlast  <= skid_tlast;
                    m_tvalid <= 1'b1;
                end else if (keep) begin
                    m_tdata  <= s_tdata;
                    m_tkeep  <= s_tkeep;
                    m_tuser  <= s_tuser;
                    m_tlast  <= s_tlast;
                    m_tvalid <= 1'b1;
                end else begin
                    m_tvalid <= 1'b0;
                end
            end else if (keep) begin
                skid_tdata <= s_tdata;
                skid_tkeep <= s_tkeep;
                skid_tuser <= s_tuser;
                skid_tlast <= s_tlast;
            end
            skid_valid <= skid_nxt;
            s_tready   <= ~skid_nxt;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state         <= WAIT_SOF;
            x             <= '0;
            y             <= '0;
            w_q           <= '0;
            h_q           <= '0;
            frame_err     <= 1'b0;
            meas_width_o  <= '0;
            meas_height_o <= '0;
        end else if (keep) begin
            if (s_tuser) begin
                w_q <= cfg_width_i;
                h_q <= cfg_height_i;
            end
            frame_err <= err_prior | early | late;
            if (s_tlast) begin
                x            <= '0;
                y            <= sat12(y1);
                meas_width_o <= sat12(x1);
            end else begin
                x <= sat12(x1);
                y <= cy;
            end
            if (frame_end) begin
                meas_height_o <= eff_h;
                state         <= WAIT_SOF;
            end else begin
                if (mid_sof) begin
                    meas_height_o <= y;
                end
                state <= IN_FRAME;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn || clear_i) begin
            frame_cnt_o     <= '0;
            drop_cnt_o      <= '0;
            err_eol_early_o <= '0;
            err_eol_late_o  <= '0;
            err_sof_o       <= '0;
        end else begin
            frame_cnt_o     <= bump(frame_cnt_o, frame_ok);
            drop_cnt_o      <= bump(drop_cnt_o, drop);
            err_eol_early_o <= bump(err_eol_early_o, early);
            err_eol_late_o  <= bump(err_eol_late_o, late);
            err_sof_o       <= bump(err_sof_o, sof_err);
        end
    end

endmodule

// File: doc/axis_video_frame_chk.md
Name: axis_video_frame_chk

Overview:
- Sits between video_ctrl_top's AXI4-Stream video output and the VDMA S2MM slave port.
- Aligns the stream to frame boundaries: beats arriving before the first start-of-frame (SOF, TUSER) are discarded, so the VDMA only ever sees frames that begin with SOF.
- Checks every frame against the configured width and height, and exposes error, drop and frame counters for sys_ctrl readback.
- Registered pass-through with a two-entry skid buffer; full throughput.

Parameters:
- DW, 16, TDATA width in bits (YUV 4:2:2, one pixel per beat).
- CNT_W, 16, width of every status counter.

Ports:
- ACLK  input  1  stream clock.
- ARESETn  input  1  synchronous active-low reset.
- s_tdata  input  DW  upstream data.
- s_tkeep  input  DW/8  upstream byte enables.
- s_tuser  input  1  SOF.
- s_tlast  input  1  end-of-line (EOL).
- s_tvalid  input  1  upstream valid.
- s_tready  output  1  ready to upstream.
- m_tdata  output  DW  data to VDMA.
- m_tkeep  output  DW/8  byte enables to VDMA.
- m_tuser  output  1  SOF to VDMA.
- m_tlast  output  1  EOL to VDMA.
- m_tvalid  output  1  valid to VDMA.
- m_tready  input  1  VDMA ready.
- cfg_width_i  input  12  pixels per line; 0 disables checks.
- cfg_height_i  input  12  lines per frame; 0 disables checks.
- clear_i  input  1  one-cycle pulse; zeroes all status counters.
- frame_cnt_o  output  CNT_W  frames completed with correct geometry.
- drop_cnt_o  output  CNT_W  beats discarded while unaligned.
- err_eol_early_o  output  CNT_W  TLAST seen before cfg_width.
- err_eol_late_o  output  CNT_W  no TLAST at beat cfg_width.
- err_sof_o  output  CNT_W  TUSER received mid-frame.
- meas_width_o  output  12  beat count of the last line received.
- meas_height_o  output  12  line count of the last frame received.

Behaviour:
- Clocking/reset: single ACLK domain. While ARESETn=0 all of the following hold:
  - s_tready=0, m_tvalid=0, both skid entries invalid.
  - state=WAIT_SOF, x=0, y=0.
  - All counters and meas_* are 0.
  - m_tdata/m_tkeep/m_tuser/m_tlast are 0.
- Reset mid-frame flushes buffered beats; no partial frame is forwarded afterwards.
- Accept = s_tvalid & s_tready. Forward = m_tvalid & m_tready.
- Skid buffer:
  - s_tready = ~skid_valid, registered.
  - An accepted beat that is forwarded appears on m_* the cycle after acceptance (latency 1).
  - If m_tready is low, the output holds its beat and a second accepted beat goes into the skid register; s_tready then drops the next cycle.
  - m_* must be stable while m_tvalid=1 and m_tready=0.
  - Sustained 1 beat/cycle when m_tready=1.
- Geometry latch: on every accepted SOF beat, latch W=cfg_width_i and H=cfg_height_i. Mid-frame cfg changes have no effect until the next SOF.
- State WAIT_SOF:
  - Accepted beat with tuser=0: discarded (not forwarded), drop_cnt_o+1.
  - Accepted beat with tuser=1: forwarded; x and y restart at this beat; go to IN_FRAME.
- State IN_FRAME (all accepted beats are forwarded):
  - tuser=1 when (x,y)≠(0,0): err_sof_o+1; meas_height_o=y; restart x,y at this beat; stay in IN_FRAME.
  - tlast=1 with x+1<W: err_eol_early_o+1.
  - Beat with x+1==W and tlast=0: err_eol_late_o+1, counted once per line. Counting continues until TLAST arrives.
  - tlast=1: meas_width_o=x+1, x=0, y=y+1.
  - tlast=1 with y+1==H: meas_height_o=H; frame_cnt_o+1 only if no error was counted during this frame; go to WAIT_SOF.
  - tuser and tlast on the same beat is legal (single-pixel line).
  - x and y are 12 bits and saturate at 4095.
- W=0 or H=0: no EOL or SOF errors are counted and no frame end is detected; meas_* still update.
- Counters saturate at all-ones.
- clear_i zeroes all counters the next cycle. Clear wins over a same-cycle increment. clear_i does not affect state, x/y or meas_*.

Test Plan:
- W=16, H=10: 3 clean frames, m_tready=1 → 160 beats/frame forwarded, latency 1, frame_cnt=3, all error counters 0, meas_width=16, meas_height=10.
- 5 beats without TUSER before the first SOF → drop_cnt=5; first m_tvalid beat has m_tuser=1.
- Line 3 carries TLAST on beat 12 (W=16) → err_eol_early=1, meas_width=12, frame_cnt unchanged for that frame.
- Line 5 is 20 beats, no TLAST at beat 16 → err_eol_late=1 (once), meas_width=20.
- TUSER on line 6 → err_sof=1, meas_height=6; the new frame then completes → frame_cnt+1.
- Random m_tready toggling at 50% over 2 frames → no beat lost or duplicated, m_* stable while stalled; ARESETn low mid-frame → m_tvalid=0 the next cycle and counters=0; clear_i coincident with a frame end → frame_cnt=0.
